// File: rtl/wb_write_buffer_if.sv
// Writeback request handshake between the pipeline and the write buffer.
// The master offers {reg, data} and the slave answers with wb_ready.
interface wb_write_buffer_if;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        wb_ready;

  modport master (
    output wb_valid,
    output wb_reg,
    output wb_data,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_reg,
    input  wb_data,
    output wb_ready
  );
endinterface

// File: rtl/wb_write_buffer.sv
// In-order writeback buffer draining into the register file, with read bypass.
// Define WB_BYPASS_EN to forward buffered data onto ReadData1/ReadData2.
module wb_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  wb_write_buffer_if.slave           wb,
  input  logic                       hold,
  output logic                       RegWrite,
  output logic [4:0]                 WriteRegister,
  output logic [63:0]                WriteData,
  input  logic [4:0]                 ReadRegister1,
  input  logic [4:0]                 ReadRegister2,
  input  logic [63:0]                RegData1,
  input  logic [63:0]                RegData2,
  output logic [63:0]                ReadData1,
  output logic [63:0]                ReadData2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    regs [DEPTH];
  logic [63:0]   dat  [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic          enq;
  logic          deq;

  assign wb.wb_ready = (count < CW'(DEPTH));
  assign RegWrite    = (count != '0) && !hold;
  assign deq         = RegWrite;
  // Writes to x31 are swallowed: accepted but never stored.
  assign enq = wb.wb_valid && wb.wb_ready && (wb.wb_reg != 5'd31);

  assign WriteRegister = vld[rdPtr] ? regs[rdPtr] : 5'd0;
  assign WriteData     = vld[rdPtr] ? dat[rdPtr]  : 64'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      rdPtr <= '0;
      wrPtr <= '0;
      vld   <= '0;
    end else begin
      if (deq) begin
        vld[rdPtr] <= 1'b0;
        rdPtr      <= rdPtr + AW'(1);
      end
      if (enq) begin
        vld[wrPtr] <= 1'b1;
        wrPtr      <= wrPtr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      regs[wrPtr] <= wb.wb_reg;
      dat[wrPtr]  <= wb.wb_data;
    end
  end

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    ReadData1 = RegData1;
    ReadData2 = RegData2;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[rdPtr + AW'(i)] &&
          regs[rdPtr + AW'(i)] == ReadRegister1)
        ReadData1 = dat[rdPtr + AW'(i)];
      if (vld[rdPtr + AW'(i)] &&
          regs[rdPtr + AW'(i)] == ReadRegister2)
        ReadData2 = dat[rdPtr + AW'(i)];
    end
    if (ReadRegister1 == 5'd31) ReadData1 = 64'd0;
    if (ReadRegister2 == 5'd31) ReadData2 = 64'd0;
  end
`else
  always_comb begin
    ReadData1 = (ReadRegister1 == 5'd31) ? 64'd0 : RegData1;
    ReadData2 = (ReadRegister2 == 5'd31) ? 64'd0 : RegData2;
  end
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
// Directed-vector bench for wb_write_buffer (DEPTH = 4).
// Expected bypass values follow WB_BYPASS_EN.
module tb_wb_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [63:0] RegData1, RegData2;
  logic [63:0] ReadData1, ReadData2;
  logic [2:0]  count;

  int nVec  = 0;
  int nMiss = 0;

  wb_write_buffer_if wbIf ();

  wb_write_buffer #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb            (wbIf.slave),
    .hold          (hold),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .RegData1      (RegData1),
    .RegData2      (RegData2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [4:0] r,
                       input logic [63:0] d);
    wbIf.wb_valid = v;
    wbIf.wb_reg   = r;
    wbIf.wb_data  = d;
  endtask

  logic [63:0] expBy;

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    drive(1'b0, 5'd0, 64'd0);
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd31;
    RegData1 = 64'd77;
    RegData2 = 64'd55;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_wreg", 64'(WriteRegister), 64'd0);
    chk("rst_wdata", WriteData, 64'd0);
    chk("rst_ready", 64'(wbIf.wb_ready), 64'd1);
    chk("rst_rd1", ReadData1, 64'd77);
    chk("rst_rd2_x31", ReadData2, 64'd0);

    // single write, minimum latency
    drive(1'b1, 5'd5, 64'hA5);
    step();
    drive(1'b0, 5'd0, 64'd0);
    chk("lat_regwrite", 64'(RegWrite), 64'd1);
    chk("lat_wreg", 64'(WriteRegister), 64'd5);
    chk("lat_wdata", WriteData, 64'hA5);
    chk("lat_count", 64'(count), 64'd1);
    step();
    chk("lat_count0", 64'(count), 64'd0);
    chk("lat_regwrite0", 64'(RegWrite), 64'd0);

    // hold and fill, then drain in order
    hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 64'h10 + 64'(i - 1));
      step();
    end
    drive(1'b0, 5'd0, 64'd0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(wbIf.wb_ready), 64'd0);
    chk("full_regwrite", 64'(RegWrite), 64'd0);
    ReadRegister1 = 5'd3;
    RegData1 = 64'd77;
    #1;
`ifdef WB_BYPASS_EN
    expBy = 64'h12;
`else
    expBy = 64'd77;
`endif
    chk("full_bypass", ReadData1, expBy);
    hold = 1'b0;
    #1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_regwrite", 64'(RegWrite), 64'd1);
      chk("drain_wreg", 64'(WriteRegister), 64'(i));
      chk("drain_wdata", WriteData, 64'h10 + 64'(i - 1));
      step();
    end
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_idle", 64'(RegWrite), 64'd0);

    // x31 writes are discarded
    drive(1'b1, 5'd31, 64'hFF);
    step();
    drive(1'b0, 5'd0, 64'd0);
    chk("x31_count", 64'(count), 64'd0);
    chk("x31_regwrite", 64'(RegWrite), 64'd0);
    step();
    chk("x31_regwrite2", 64'(RegWrite), 64'd0);
    ReadRegister1 = 5'd31;
    RegData1 = 64'd123;
    #1;
    chk("x31_read", ReadData1, 64'd0);

    // youngest match wins
    hold = 1'b1;
    drive(1'b1, 5'd7, 64'h1);
    step();
    drive(1'b1, 5'd7, 64'h2);
    step();
    drive(1'b0, 5'd0, 64'd0);
    ReadRegister1 = 5'd7;
    RegData1 = 64'h9;
    ReadRegister2 = 5'd8;
    RegData2 = 64'h44;
    #1;
`ifdef WB_BYPASS_EN
    expBy = 64'h2;
`else
    expBy = 64'h9;
`endif
    chk("byp_young", ReadData1, expBy);
    chk("byp_nomatch", ReadData2, 64'h44);
    chk("byp_count", 64'(count), 64'd2);
    // not-yet-stored request is excluded
    ReadRegister2 = 5'd9;
    drive(1'b1, 5'd9, 64'h77);
    #1;
    chk("byp_inflight", ReadData2, 64'h44);
    drive(1'b0, 5'd0, 64'd0);
    hold = 1'b0;
    step();
    step();
    chk("byp_drained", 64'(count), 64'd0);

    // full with concurrent drain: ready stays low
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(10 + i), 64'h20 + 64'(i));
      step();
    end
    hold = 1'b0;
    drive(1'b1, 5'd20, 64'h30);
    #1;
    chk("fd_ready0", 64'(wbIf.wb_ready), 64'd0);
    chk("fd_regwrite", 64'(RegWrite), 64'd1);
    step();
    chk("fd_count3", 64'(count), 64'd3);
    chk("fd_ready1", 64'(wbIf.wb_ready), 64'd1);
    step();
    drive(1'b0, 5'd0, 64'd0);
    chk("fd_count3b", 64'(count), 64'd3);
    chk("fd_head", 64'(WriteRegister), 64'd12);
    chk("fd_headdata", WriteData, 64'h22);

    // reset drops pending entries
    hold = 1'b1;
    #1;
    chk("rs_pre", 64'(count), 64'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    hold = 1'b0;
    #1;
    chk("rs_count", 64'(count), 64'd0);
    chk("rs_regwrite", 64'(RegWrite), 64'd0);
    chk("rs_ready", 64'(wbIf.wb_ready), 64'd1);
    chk("rs_wreg", 64'(WriteRegister), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rs_nowrite", 64'(RegWrite), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
